// File: rtl/mem_access_unit_pkg.sv
// Shared pipeline definitions: data-size encodings and MEM-stage FSM states.
package mem_access_unit_pkg;

  localparam logic [1:0] DSIZE_BYTE = 2'b00;
  localparam logic [1:0] DSIZE_HALF = 2'b01;
  localparam logic [1:0] DSIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_ERR  = 2'b10
  } state_t;

endpackage

// File: rtl/load_align.sv
// Load lane select and extension.
// Ports: rdata (bus word), addr (byte offset), dsize, loadext (1 = sign) -> data.
// Lanes are big-endian: byte offset 0 is rdata[31:24].
module load_align
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [1:0]  dsize,
  input  logic        loadext,
  output logic [31:0] data
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  always_comb begin
    byte_val = '0;
    case (addr)
      2'd0:    byte_val = rdata[31:24];
      2'd1:    byte_val = rdata[23:16];
      2'd2:    byte_val = rdata[15:8];
      default: byte_val = rdata[7:0];
    endcase
    half_val = addr[1] ? rdata[15:0] : rdata[31:16];
  end

  always_comb begin
    data = rdata;
    case (dsize)
      DSIZE_BYTE: data = {{24{loadext & byte_val[7]}}, byte_val};
      DSIZE_HALF: data = {{16{loadext & half_val[15]}}, half_val};
      default:    data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data access unit: one req/ack transaction per load or store,
// load extraction, pipeline stall and the MEM/WB register.
// Ports: EX/MEM fields (mem_*), data bus (dmem_*), stall, MEM/WB fields (wb_*).
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_memwr,
  input  logic        mem_memtoreg,
  input  logic        mem_regwr,
  input  logic        mem_loadext,
  input  logic        mem_jal,
  input  logic [1:0]  mem_dsize,
  input  logic [1:0]  mem_fpoint,
  input  logic [4:0]  mem_rw,
  input  logic [31:0] mem_execresult,
  input  logic [31:0] mem_busb,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall,
  output logic        wb_regwr,
  output logic        wb_memtoreg,
  output logic        wb_jal,
  output logic [4:0]  wb_rw,
  output logic [1:0]  wb_fpoint,
  output logic [31:0] wb_result,
  output logic [31:0] wb_memdata,
  output logic        wb_misalign,
  output logic        wb_buserr
);

  localparam int unsigned   CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t        state;
  logic [CW-1:0] cnt;

  logic        access;
  logic        misalign;
  logic        mis_acc;
  logic        go;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [31:0] load_data;

  logic        n_regwr;
  logic        n_memtoreg;
  logic        n_jal;
  logic        n_misalign;
  logic        n_buserr;
  logic [31:0] n_memdata;

  always_comb begin
    access   = mem_memwr | mem_memtoreg;
    misalign = ((mem_dsize == DSIZE_HALF) & mem_execresult[0]) |
               (mem_dsize[1] & (|mem_execresult[1:0]));
    mis_acc  = access & misalign;
    go       = access & ~misalign;
  end

  always_comb begin
    be_c    = 4'b1111;
    wdata_c = mem_busb;
    case (mem_dsize)
      DSIZE_BYTE: begin
        be_c    = 4'b1000 >> mem_execresult[1:0];
        wdata_c = {4{mem_busb[7:0]}};
      end
      DSIZE_HALF: begin
        be_c    = mem_execresult[1] ? 4'b0011 : 4'b1100;
        wdata_c = {2{mem_busb[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = mem_busb;
      end
    endcase
  end

  assign stall = ((state == ST_IDLE) & go) |
                 ((state == ST_BUSY) & ~dmem_ack) |
                 (state == ST_ERR);

  load_align u_load_align (
    .rdata   (dmem_rdata),
    .addr    (mem_execresult[1:0]),
    .dsize   (mem_dsize),
    .loadext (mem_loadext),
    .data    (load_data)
  );

  // Defaults form the bubble; each state overrides only when the
  // instruction actually retires into MEM/WB this cycle.
  always_comb begin
    n_regwr    = 1'b0;
    n_memtoreg = 1'b0;
    n_jal      = 1'b0;
    n_misalign = 1'b0;
    n_buserr   = 1'b0;
    n_memdata  = '0;
    case (state)
      ST_IDLE: begin
        if (!go) begin
          n_regwr    = mem_regwr & ~mis_acc;
          n_memtoreg = mem_memtoreg;
          n_jal      = mem_jal;
          n_misalign = mis_acc;
        end
      end
      ST_BUSY: begin
        if (dmem_ack) begin
          n_regwr    = mem_regwr;
          n_memtoreg = mem_memtoreg;
          n_jal      = mem_jal;
          n_memdata  = mem_memwr ? '0 : load_data;
        end
      end
      ST_ERR: begin
        n_memtoreg = mem_memtoreg;
        n_jal      = mem_jal;
        n_buserr   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_addr   <= '0;
      dmem_be     <= '0;
      dmem_wdata  <= '0;
      wb_regwr    <= 1'b0;
      wb_memtoreg <= 1'b0;
      wb_jal      <= 1'b0;
      wb_rw       <= '0;
      wb_fpoint   <= '0;
      wb_result   <= '0;
      wb_memdata  <= '0;
      wb_misalign <= 1'b0;
      wb_buserr   <= 1'b0;
    end else begin
      wb_regwr    <= n_regwr;
      wb_memtoreg <= n_memtoreg;
      wb_jal      <= n_jal;
      wb_misalign <= n_misalign;
      wb_buserr   <= n_buserr;
      wb_memdata  <= n_memdata;
      wb_rw       <= mem_rw;
      wb_fpoint   <= mem_fpoint;
      wb_result   <= mem_execresult;

      case (state)
        ST_IDLE: begin
          if (go) begin
            state      <= ST_BUSY;
            cnt        <= '0;
            dmem_req   <= 1'b1;
            dmem_we    <= mem_memwr;
            dmem_addr  <= {mem_execresult[31:2], 2'b00};
            dmem_be    <= be_c;
            dmem_wdata <= wdata_c;
          end
        end
        ST_BUSY: begin
          if (dmem_ack) begin
            state    <= ST_IDLE;
            dmem_req <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
            // Ack takes priority over the final count.
            if (cnt == CNT_LAST) begin
              state    <= ST_ERR;
              dmem_req <= 1'b0;
            end
          end
        end
        ST_ERR: begin
          state    <= ST_IDLE;
          dmem_req <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  localparam int unsigned TIMEOUT = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        mem_memwr, mem_memtoreg, mem_regwr, mem_loadext, mem_jal;
  logic [1:0]  mem_dsize, mem_fpoint;
  logic [4:0]  mem_rw;
  logic [31:0] mem_execresult, mem_busb;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic        stall;
  logic        wb_regwr, wb_memtoreg, wb_jal;
  logic [4:0]  wb_rw;
  logic [1:0]  wb_fpoint;
  logic [31:0] wb_result, wb_memdata;
  logic        wb_misalign, wb_buserr;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  mem_access_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clock          (clock),
    .reset          (reset),
    .mem_memwr      (mem_memwr),
    .mem_memtoreg   (mem_memtoreg),
    .mem_regwr      (mem_regwr),
    .mem_loadext    (mem_loadext),
    .mem_jal        (mem_jal),
    .mem_dsize      (mem_dsize),
    .mem_fpoint     (mem_fpoint),
    .mem_rw         (mem_rw),
    .mem_execresult (mem_execresult),
    .mem_busb       (mem_busb),
    .dmem_req       (dmem_req),
    .dmem_we        (dmem_we),
    .dmem_addr      (dmem_addr),
    .dmem_be        (dmem_be),
    .dmem_wdata     (dmem_wdata),
    .dmem_rdata     (dmem_rdata),
    .dmem_ack       (dmem_ack),
    .stall          (stall),
    .wb_regwr       (wb_regwr),
    .wb_memtoreg    (wb_memtoreg),
    .wb_jal         (wb_jal),
    .wb_rw          (wb_rw),
    .wb_fpoint      (wb_fpoint),
    .wb_result      (wb_result),
    .wb_memdata     (wb_memdata),
    .wb_misalign    (wb_misalign),
    .wb_buserr      (wb_buserr)
  );

  task automatic drive(input logic wr, input logic rd, input logic rgw, input logic ext,
                       input logic jal, input logic [1:0] ds, input logic [1:0] fp,
                       input logic [4:0] rw, input logic [31:0] addr, input logic [31:0] busb);
    mem_memwr      = wr;
    mem_memtoreg   = rd;
    mem_regwr      = rgw;
    mem_loadext    = ext;
    mem_jal        = jal;
    mem_dsize      = ds;
    mem_fpoint     = fp;
    mem_rw         = rw;
    mem_execresult = addr;
    mem_busb       = busb;
  endtask

  // One instruction through MEM. ack_cyc = BUSY cycle (1-based) carrying ack; 0 = never.
  task automatic do_access(input string tag, input logic wr, input logic rd, input logic rgw,
                           input logic ext, input logic jal, input logic [1:0] ds,
                           input logic [1:0] fp, input logic [4:0] rw, input logic [31:0] addr,
                           input logic [31:0] busb, input logic [31:0] rdata, input int ack_cyc);
    int          bytes, off, stalls;
    logic        need, mis, got;
    logic [3:0]  e_be;
    logic [31:0] e_wd, e_md;
    logic [63:0] val, mask;

    bytes = (ds == 2'd0) ? 1 : (ds == 2'd1) ? 2 : 4;
    off   = int'(addr[1:0]);
    need  = wr | rd;
    mis   = (off % bytes) != 0;
    e_be  = '0;
    e_wd  = '0;
    for (int i = 0; i < 4; i++) begin
      e_be[3-i]        = (i >= off) && (i < off + bytes);
      e_wd[8*(3-i) +: 8] = 8'(busb >> (8 * (bytes - 1 - (i % bytes))));
    end
    val = '0;
    for (int k = 0; k < bytes; k++)
      if (off + k < 4) val = (val << 8) | 64'(8'(rdata >> (8 * (3 - (off + k)))));
    mask = (64'd1 << (8 * bytes)) - 64'd1;
    if (ext && val[8*bytes-1]) val = val | ~mask;
    e_md = wr ? 32'h0 : val[31:0];

    @(negedge clock);
    drive(wr, rd, rgw, ext, jal, ds, fp, rw, addr, busb);
    dmem_ack   = 1'b0;
    dmem_rdata = $urandom;
    #1;

    if (!need || mis) begin
      n_checks++;
      if (stall !== 1'b0) $display("FAIL %s stall_nobus: got %b want 0", tag, stall);
      else n_pass++;
      @(posedge clock); #1;
      n_checks++;
      if (dmem_req !== 1'b0) $display("FAIL %s req_nobus: got %b want 0", tag, dmem_req);
      else n_pass++;
      n_checks++;
      if (!need) begin
        if ({wb_regwr, wb_memtoreg, wb_jal, wb_rw, wb_fpoint, wb_result, wb_memdata, wb_misalign, wb_buserr}
            !== {rgw, 1'b0, jal, rw, fp, addr, 32'h0, 1'b0, 1'b0})
          $display("FAIL %s wb_nomem: got %b_%b_%b_%h_%h_%h_%h_%b_%b want %b_0_%b_%h_%h_%h_0_0_0",
                   tag, wb_regwr, wb_memtoreg, wb_jal, wb_rw, wb_fpoint, wb_result, wb_memdata,
                   wb_misalign, wb_buserr, rgw, jal, rw, fp, addr);
        else n_pass++;
      end else begin
        if ({wb_regwr, wb_rw, wb_result, wb_misalign, wb_buserr} !== {1'b0, rw, addr, 1'b1, 1'b0})
          $display("FAIL %s wb_misalign: got regwr=%b rw=%h res=%h mis=%b berr=%b want 0 %h %h 1 0",
                   tag, wb_regwr, wb_rw, wb_result, wb_misalign, wb_buserr, rw, addr);
        else n_pass++;
      end
      return;
    end

    n_checks++;
    if ({stall, dmem_req} !== 2'b10)
      $display("FAIL %s idle_cycle: got stall=%b req=%b want 1 0", tag, stall, dmem_req);
    else n_pass++;
    stalls = 1;
    got    = 1'b0;
    @(posedge clock);

    for (int n = 1; n <= int'(TIMEOUT); n++) begin
      @(negedge clock);
      n_checks++;
      if ({dmem_req, dmem_we, dmem_addr, dmem_be} !== {1'b1, wr, addr & 32'hFFFF_FFFC, e_be})
        $display("FAIL %s bus_req c%0d: got req=%b we=%b addr=%h be=%b want 1 %b %h %b",
                 tag, n, dmem_req, dmem_we, dmem_addr, dmem_be, wr, addr & 32'hFFFF_FFFC, e_be);
      else n_pass++;
      if (wr) begin
        n_checks++;
        if (dmem_wdata !== e_wd) $display("FAIL %s wdata c%0d: got %h want %h", tag, n, dmem_wdata, e_wd);
        else n_pass++;
      end
      n_checks++;
      if ({wb_regwr, wb_memtoreg, wb_jal, wb_misalign, wb_buserr} !== 5'b0)
        $display("FAIL %s bubble c%0d: got %b want 00000", tag, n,
                 {wb_regwr, wb_memtoreg, wb_jal, wb_misalign, wb_buserr});
      else n_pass++;
      if (n == ack_cyc) begin
        dmem_ack   = 1'b1;
        dmem_rdata = rdata;
        got        = 1'b1;
        #1;
        n_checks++;
        if (stall !== 1'b0) $display("FAIL %s stall_ack: got %b want 0", tag, stall);
        else n_pass++;
      end else begin
        dmem_rdata = $urandom;
        #1;
        n_checks++;
        if (stall !== 1'b1) $display("FAIL %s stall_wait c%0d: got %b want 1", tag, n, stall);
        else n_pass++;
        stalls++;
      end
      @(posedge clock); #1;
      dmem_ack = 1'b0;
      if (got) break;
    end

    if (got) begin
      n_checks++;
      if (stalls != ack_cyc) $display("FAIL %s stall_cycles: got %0d want %0d", tag, stalls, ack_cyc);
      else n_pass++;
      n_checks++;
      if (dmem_req !== 1'b0) $display("FAIL %s req_drop: got %b want 0", tag, dmem_req);
      else n_pass++;
      n_checks++;
      if ({wb_regwr, wb_memtoreg, wb_jal, wb_rw, wb_fpoint, wb_result, wb_memdata, wb_misalign, wb_buserr}
          !== {rgw, rd, jal, rw, fp, addr, e_md, 1'b0, 1'b0})
        $display("FAIL %s wb_done: got %b_%b_%b_%h_%h_%h_%h_%b_%b want %b_%b_%b_%h_%h_%h_%h_0_0",
                 tag, wb_regwr, wb_memtoreg, wb_jal, wb_rw, wb_fpoint, wb_result, wb_memdata,
                 wb_misalign, wb_buserr, rgw, rd, jal, rw, fp, addr, e_md);
      else n_pass++;
    end else begin
      @(negedge clock);
      dmem_ack = 1'b1;
      #1;
      n_checks++;
      if (stall !== 1'b1) $display("FAIL %s stall_err: got %b want 1", tag, stall);
      else n_pass++;
      @(posedge clock); #1;
      dmem_ack = 1'b0;
      n_checks++;
      if ({wb_regwr, wb_misalign, wb_buserr, wb_rw, dmem_req} !== {1'b0, 1'b0, 1'b1, rw, 1'b0})
        $display("FAIL %s buserr: got regwr=%b mis=%b berr=%b rw=%h req=%b want 0 0 1 %h 0",
                 tag, wb_regwr, wb_misalign, wb_buserr, wb_rw, dmem_req, rw);
      else n_pass++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 2'd0, 2'd0, 5'd0, 32'h0, 32'h0);
    dmem_ack   = 1'b0;
    dmem_rdata = '0;
    repeat (2) @(posedge clock);
    #1;
    n_checks++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, stall, wb_regwr, wb_memtoreg, wb_jal,
         wb_rw, wb_fpoint, wb_result, wb_memdata, wb_misalign, wb_buserr} !== '0)
      $display("FAIL reset_state: got req=%b addr=%h be=%b wd=%h stall=%b regwr=%b res=%h md=%h want all 0",
               dmem_req, dmem_addr, dmem_be, dmem_wdata, stall, wb_regwr, wb_result, wb_memdata);
    else n_pass++;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_nonmem;
    do_access("nonmem", 0, 0, 1, 0, 0, 2'd2, 2'd0, 5'd5, 32'h0000_1234, 32'h0, 32'h0, 1);
    do_access("nonmem_jal", 0, 0, 1, 1, 1, 2'd1, 2'd3, 5'd31, 32'hDEAD_BEEF, 32'h5, 32'h0, 1);
  endtask

  task automatic test_directed;
    do_access("ld_byte", 0, 1, 1, 1, 0, 2'd0, 2'd1, 5'd7, 32'h0000_0102, 32'h0, 32'h1122_8344, 1);
    n_checks++;
    if (wb_memdata !== 32'hFFFF_FF83) $display("FAIL ld_byte_const: got %h want ffffff83", wb_memdata);
    else n_pass++;
    do_access("st_half", 1, 0, 0, 0, 0, 2'd1, 2'd0, 5'd3, 32'h0000_0202, 32'hABCD_1234, 32'h0, 3);
    do_access("ld_word_mis", 0, 1, 1, 0, 0, 2'd2, 2'd0, 5'd9, 32'h0000_0006, 32'h0, 32'h0, 1);
    do_access("ld_half_mis", 0, 1, 1, 1, 0, 2'd1, 2'd0, 5'd9, 32'h0000_0013, 32'h0, 32'h0, 1);
    do_access("ld_half_zx", 0, 1, 1, 0, 0, 2'd1, 2'd0, 5'd4, 32'h0000_0042, 32'h0, 32'h1234_F00D, 2);
    do_access("ld_dsize3", 0, 1, 1, 1, 0, 2'd3, 2'd2, 5'd6, 32'h0000_0080, 32'h0, 32'h8765_4321, 1);
    do_access("st_byte0", 1, 0, 0, 0, 0, 2'd0, 2'd0, 5'd0, 32'h0000_0300, 32'h0000_00A5, 32'h0, 2);
    do_access("ack_at_limit", 0, 1, 1, 1, 0, 2'd0, 2'd0, 5'd8, 32'h0000_0403, 32'h0, 32'hCAFE_BA80, int'(TIMEOUT));
    do_access("timeout", 0, 1, 1, 0, 0, 2'd2, 2'd0, 5'd10, 32'h0000_0500, 32'h0, 32'h0, 0);
  endtask

  task automatic test_back_to_back;
    do_access("b2b_ld", 0, 1, 1, 1, 0, 2'd2, 2'd0, 5'd11, 32'h0000_1000, 32'h0, 32'h0BAD_F00D, 1);
    do_access("b2b_st", 1, 0, 0, 0, 0, 2'd2, 2'd0, 5'd12, 32'h0000_1004, 32'h1357_9BDF, 32'h0, 1);
    do_access("b2b_ld2", 0, 1, 1, 1, 1, 2'd1, 2'd1, 5'd13, 32'h0000_1006, 32'h0, 32'h0000_8001, 2);
  endtask

  task automatic test_reset_mid_busy;
    @(negedge clock);
    drive(0, 1, 1, 1, 0, 2'd0, 2'd0, 5'd14, 32'h0000_0700, 32'h0);
    dmem_ack = 1'b0;
    @(posedge clock);
    @(negedge clock);
    n_checks++;
    if (dmem_req !== 1'b1) $display("FAIL rst_busy_req: got %b want 1", dmem_req);
    else n_pass++;
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 2'd0, 2'd0, 5'd0, 32'h0, 32'h0);
    @(posedge clock); #1;
    n_checks++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, wb_regwr, wb_memtoreg, wb_jal,
         wb_rw, wb_fpoint, wb_result, wb_memdata, wb_misalign, wb_buserr} !== '0)
      $display("FAIL rst_busy_outputs: got req=%b addr=%h be=%b regwr=%b res=%h want all 0",
               dmem_req, dmem_addr, dmem_be, wb_regwr, wb_result);
    else n_pass++;
    @(negedge clock);
    reset      = 1'b0;
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hFFFF_FFFF;
    #1;
    n_checks++;
    if (stall !== 1'b0) $display("FAIL rst_late_ack_stall: got %b want 0", stall);
    else n_pass++;
    @(posedge clock); #1;
    dmem_ack = 1'b0;
    n_checks++;
    if ({dmem_req, wb_regwr, wb_memtoreg, wb_memdata, wb_buserr} !== '0)
      $display("FAIL rst_late_ack: got req=%b regwr=%b mtr=%b md=%h berr=%b want all 0",
               dmem_req, wb_regwr, wb_memtoreg, wb_memdata, wb_buserr);
    else n_pass++;
    @(posedge clock); #1;
    n_checks++;
    if ({dmem_req, stall} !== 2'b00) $display("FAIL rst_stay_idle: got req=%b stall=%b want 0 0", dmem_req, stall);
    else n_pass++;
  endtask

  task automatic test_random;
    for (int it = 0; it < 60; it++) begin
      logic [31:0] a;
      logic [1:0]  ds;
      int          kind;
      kind = $urandom_range(0, 3);
      ds   = 2'($urandom_range(0, 3));
      a    = $urandom;
      if ($urandom_range(0, 2) != 0)
        a[1:0] = (ds == 2'd0) ? a[1:0] : (ds == 2'd1) ? {a[1], 1'b0} : 2'b00;
      do_access("random", kind >= 2, kind == 1 || kind == 3, 1'($urandom), 1'($urandom),
                1'($urandom), ds, 2'($urandom), 5'($urandom), a, $urandom, $urandom,
                $urandom_range(0, int'(TIMEOUT)));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_nonmem();
    test_directed();
    test_back_to_back();
    test_reset_mid_busy();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
